spart_tx: RTL

Serial transmit stage of the mini SPART: takes parallel bytes from the bus side and shifts them out as an asynchronous 8-data-bit, no-parity frame on `TxD`. It is the upstream peer of the SPART receiver. It shares the same `Baud` enable, which pulses at 16x the bit rate, so a `spart_tx` output looped into the receiver decodes bit-exactly. A one-entry holding register in front of the shift register allows back-to-back frames with no idle gap.

---
 rtl/spart_tx_if.sv | 19 +
 rtl/spart_tx.sv | 128 ++++++++++++
 2 files changed

// File: rtl/spart_tx_if.sv
// Bus-side write port of the SPART transmitter.
// The bus drives a byte and strobe; the transmitter reports buffer ready.
interface spart_tx_if;
    logic [7:0] TxD_data;
    logic       TxD_wr;
    logic       TBR;

    modport master (
        output TxD_data,
        output TxD_wr,
        input  TBR
    );

    modport slave (
        input  TxD_data,
        input  TxD_wr,
        output TBR
    );
endinterface

// File: rtl/spart_tx.sv
// SPART transmit stage: holding register feeding an 8N1/8N2 shifter.
// Bit timing is counted in Baud pulses (OVERSAMPLE per bit).
module spart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     Baud,
    spart_tx_if.slave bus,
    output logic     TxD,
    output logic     busy
);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] shift_q, shift_d;
    logic       hold_full_q, hold_full_d;
    logic [3:0] tick_q, tick_d;
    logic [3:0] cnt_q, cnt_d;
    logic       txd_q, txd_d;
    logic       bit_end;
    logic       load;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;
        tick_d      = tick_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        txd_d       = 1'b1;

        bit_end = Baud && (tick_q == TICK_LAST);
        if (Baud && state_q != IDLE) begin
            tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
        end

        unique case (state_q)
            IDLE: begin
                load = hold_full_q;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = 4'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (cnt_q == 4'd7) begin
                        state_d = STOP;
                        cnt_d   = 4'd0;
                    end else begin
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (cnt_q == STOP_LAST) begin
                        // A queued byte chains straight into a new start bit.
                        load    = hold_full_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tick_d      = 4'd0;
            cnt_d       = 4'd0;
            state_d     = START;
        end

        // Cannot collide with load: a write needs an empty hold.
        if (bus.TxD_wr && !hold_full_q) begin
            hold_d      = bus.TxD_data;
            hold_full_d = 1'b1;
        end

        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_q      <= 8'd0;
            shift_q     <= 8'd0;
            hold_full_q <= 1'b0;
            tick_q      <= 4'd0;
            cnt_q       <= 4'd0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            hold_full_q <= hold_full_d;
            tick_q      <= tick_d;
            cnt_q       <= cnt_d;
            txd_q       <= txd_d;
        end
    end

    assign bus.TBR = ~hold_full_q;
    assign TxD     = txd_q;
    assign busy    = (state_q != IDLE);
endmodule
